// File: rtl/serie_paralelo_lane_if.sv
// serie_paralelo_lane_if: serial lane input and the deserialized parallel outputs.
// The master side drives the serial bit stream; the slave side is the deserializer.
`default_nettype none

interface serie_paralelo_lane_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output serial_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  serial_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

`default_nettype wire

// File: rtl/serie_paralelo_lane.sv
// serie_paralelo_lane: single-lane receive deserializer with COM-based byte alignment
// and lock detection; reports payload bytes in parallel once the lane is active.
`default_nettype none

module serie_paralelo_lane #(
  parameter int LOCK_COUNT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  serie_paralelo_lane_if.slave   lane
);

  localparam logic [7:0] C_COM    = 8'hBC;
  localparam logic [7:0] C_IDL    = 8'h7C;
  localparam logic [4:0] C_LOCK_W = 5'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  sr_q;
  logic [2:0]  bitcnt_q;
  logic [3:0]  comcnt_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        strobe_q;
  logic        active_q;

  // All decisions look at the byte that includes the bit sampled on this edge.
  logic [7:0]  sr_d;
  logic        w_boundary;
  logic        w_is_com;
  logic        w_lock_next;

  assign sr_d        = {sr_q[6:0], lane.serial_in};
  assign w_boundary  = (bitcnt_q == 3'd7);
  assign w_is_com    = (sr_d == C_COM);
  assign w_lock_next = (({1'b0, comcnt_q} + 5'd1) == C_LOCK_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      sr_q     <= 8'h00;
      bitcnt_q <= 3'd0;
      comcnt_q <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (w_is_com) begin
            bitcnt_q <= 3'd0;
            comcnt_q <= 4'd1;
            state_q  <= ALIGN;
          end
        end
        ALIGN: begin
          bitcnt_q <= bitcnt_q + 3'd1;
          if (w_boundary) begin
            if (w_is_com) begin
              if (comcnt_q != 4'hF) begin
                comcnt_q <= comcnt_q + 4'd1;
              end
              if (w_lock_next) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // The failed byte is consumed; hunting resumes on the next bit.
              comcnt_q <= 4'd0;
              state_q  <= HUNT;
            end
          end
        end
        ACTIVE: begin
          bitcnt_q <= bitcnt_q + 3'd1;
          if (w_boundary) begin
            data_q   <= sr_d;
            strobe_q <= 1'b1;
            valid_q  <= (sr_d != C_COM) && (sr_d != C_IDL);
          end
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

endmodule

`default_nettype wire

// File: tb/tb_serie_paralelo_lane.sv
// tb_serie_paralelo_lane: table-driven lane scenarios, hand-written reset sequences and
// randomized streams checked against a whole-stream alignment model.
`default_nettype none

module tb_serie_paralelo_lane;

  localparam int         LOCK = 4;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDL  = 8'h7C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serie_paralelo_lane_if bus ();

  serie_paralelo_lane #(.LOCK_COUNT(LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lane  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation bookkeeping since the last reset release.
  int edge_no;
  int lock_edge;
  int n_strobes;
  int n_valids;
  int last_strobe;
  int gap_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    edge_no     = 0;
    lock_edge   = 0;
    n_strobes   = 0;
    n_valids    = 0;
    last_strobe = -1;
    gap_bad     = 0;
  endtask

  task automatic send_bit(input logic b);
    bus.serial_in = b;
    @(posedge clk);
    #1;
    edge_no++;
    if (bus.active === 1'b1 && lock_edge == 0) lock_edge = edge_no;
    if (bus.valid_out === 1'b1) n_valids++;
    if (bus.byte_strobe === 1'b1) begin
      if (last_strobe >= 0 && edge_no - last_strobe != 8) gap_bad++;
      last_strobe = edge_no;
      n_strobes++;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
  endtask

  // ---------------- table of scenarios ----------------
  typedef struct packed {
    logic [3:0]  pre_n;
    logic [7:0]  pre;
    logic [3:0]  nbytes;
    logic [79:0] bytes;     // first byte in [79:72]
    logic [7:0]  exp_lock;  // edge at which active is first seen, 0 = never
    logic [3:0]  exp_strobes;
    logic [3:0]  exp_valids;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [7];

  // ---------------- behavioural model for random streams ----------------
  logic       m_bits [$];
  logic       e_act  [$];
  logic       e_stb  [$];
  logic       e_val  [$];
  logic [7:0] e_dat  [$];

  function automatic logic [7:0] win(input int e);
    logic [7:0] w;
    w = 8'h00;
    for (int j = 0; j < 8; j++) begin
      w = {w[6:0], ((e - 7 + j) >= 0) ? m_bits[e - 7 + j] : 1'b0};
    end
    return w;
  endfunction

  // Scan the whole stream: find first COM, follow it in 8-bit steps, restart the
  // hunt one bit after a broken run, lock on the LOCK-th consecutive COM.
  task automatic build_model();
    int n;
    int e;
    int e2;
    int k;
    int lock;
    bit done;
    logic [7:0] d;
    n = m_bits.size();
    lock = -1;
    e = 0;
    done = 0;
    while (!done && e < n) begin
      if (win(e) == COM) begin
        k = 1;
        e2 = e;
        forever begin
          e2 += 8;
          if (e2 >= n) begin
            done = 1;
            break;
          end
          if (win(e2) == COM) begin
            k++;
            if (k == LOCK) begin
              lock = e2;
              done = 1;
              break;
            end
          end else begin
            e = e2 + 1;
            break;
          end
        end
      end else begin
        e++;
      end
    end
    e_act.delete(); e_stb.delete(); e_val.delete(); e_dat.delete();
    d = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic s;
      s = (lock >= 0) && (i > lock) && ((i - lock) % 8 == 0);
      if (s) d = win(i);
      e_act.push_back((lock >= 0) && (i >= lock));
      e_stb.push_back(s);
      e_val.push_back(s && d != COM && d != IDL);
      e_dat.push_back(d);
    end
  endtask

  initial begin
    bus.serial_in = 1'b0;
    clear_obs();

    vecs[0] = '{4'd0, 8'h00, 4'd5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 40'h0}, 8'd32, 4'd1, 4'd1, 8'hA5};
    vecs[1] = '{4'd3, 8'h05, 4'd5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C, 40'h0}, 8'd35, 4'd1, 4'd1, 8'h3C};
    vecs[2] = '{4'd0, 8'h00, 4'd9, {8'hBC, 8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'h00}, 8'd64, 4'd1, 4'd1, 8'h11};
    vecs[3] = '{4'd0, 8'h00, 4'd7, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C, 8'h5A, 24'h0}, 8'd32, 4'd3, 4'd1, 8'h5A};
    vecs[4] = '{4'd0, 8'h00, 4'd3, {8'h00, 8'hFF, 8'h12, 56'h0}, 8'd0, 4'd0, 4'd0, 8'h00};
    vecs[5] = '{4'd0, 8'h00, 4'd5, {8'hBC, 8'hBC, 8'hBC, 8'h7C, 8'h7C, 40'h0}, 8'd0, 4'd0, 4'd0, 8'h00};
    vecs[6] = '{4'd0, 8'h00, 4'd5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C, 40'h0}, 8'd32, 4'd1, 4'd0, 8'h7C};

    // Reset held while the line toggles: all outputs stay cleared.
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.serial_in = i[0];
      @(posedge clk);
      #1;
    end
    check("reset_hold_outputs", {bus.active, bus.valid_out, bus.byte_strobe, bus.data_out},
          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < 8; i++) send_byte((i % 2 == 0) ? 8'h00 : 8'hFF);
    check("no_com_active", {31'h0, bus.active}, 32'h0);
    check("no_com_strobes", n_strobes, 0);

    // Table-driven scenarios.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int i = int'(vecs[v].pre_n) - 1; i >= 0; i--) send_bit(vecs[v].pre[i]);
      for (int i = 0; i < int'(vecs[v].nbytes); i++) send_byte(vecs[v].bytes[79 - 8*i -: 8]);
      send_bit(1'b0);  // one extra edge lets the final pulses drop
      check($sformatf("vec%0d_lock_edge", v), lock_edge, 32'(vecs[v].exp_lock));
      check($sformatf("vec%0d_strobes", v), n_strobes, 32'(vecs[v].exp_strobes));
      check($sformatf("vec%0d_valids", v), n_valids, 32'(vecs[v].exp_valids));
      check($sformatf("vec%0d_data", v), 32'(bus.data_out), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_strobe_gap", v), gap_bad, 0);
    end

    // Reset asserted mid-byte while active clears everything at once.
    do_reset();
    repeat (4) send_byte(COM);
    send_byte(8'hA5);
    check("pre_reset_active", {bus.active, bus.valid_out, bus.data_out}, {22'h0, 1'b1, 1'b1, 8'hA5});
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {bus.active, bus.valid_out, bus.byte_strobe, bus.data_out}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    repeat (3) send_byte(COM);
    check("relock_not_early", {31'h0, bus.active}, 32'h0);
    send_byte(COM);
    check("relock_edge", lock_edge, 32);
    send_byte(8'h42);
    check("relock_data", {bus.valid_out, bus.data_out}, {23'h0, 1'b1, 8'h42});

    // Randomized streams against the whole-stream model.
    for (int t = 0; t < 20; t++) begin
      int errs;
      m_bits.delete();
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) m_bits.push_back(1'($urandom));
      if (t % 2 == 0) begin
        for (int c = 0; c < LOCK; c++)
          for (int b = 7; b >= 0; b--) m_bits.push_back(COM[b]);
      end
      for (int s = 0; s < 14; s++) begin
        logic [7:0] by;
        int r;
        int cnt;
        r = int'($urandom_range(0, 3));
        cnt = (r == 0) ? int'($urandom_range(1, 5)) : 1;
        for (int c = 0; c < cnt; c++) begin
          by = (r == 0) ? COM : (r == 2) ? IDL : 8'($urandom);
          for (int b = 7; b >= 0; b--) m_bits.push_back(by[b]);
        end
      end
      build_model();
      do_reset();
      errs = 0;
      for (int i = 0; i < m_bits.size(); i++) begin
        send_bit(m_bits[i]);
        check($sformatf("rand%0d_edge%0d", t, i),
              {21'h0, bus.active, bus.byte_strobe, bus.valid_out, bus.data_out},
              {21'h0, e_act[i], e_stb[i], e_val[i], e_dat[i]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serie_paralelo_lane.md
# serie_paralelo_lane

Single-lane receive deserializer: takes the 1-bit serial stream produced by one transmit lane, finds byte alignment by hunting for the COM symbol, and declares the lane active after a run of aligned COMs. Once the lane is active, it presents each received byte in parallel with a payload-valid pulse. One instance per lane (L0..L3) sits directly downstream of the transmit serializers; its outputs feed the receive un-striping stage.

## Interface
- COM, 8'hBC, comma/alignment symbol.
- IDL, 8'h7C, idle fill symbol, never reported as payload.
- LOCK_COUNT, 4, consecutive aligned COMs required to go active; legal range 2..15.

- clk  input  1  bit clock, one serial bit per rising edge. One clock; reset is asynchronous and active-low.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- serial_in  input  1  serial data, MSB of each byte first.
- data_out  output  8  last byte received while active.
- valid_out  output  1  one-cycle pulse: data_out holds a new payload byte (neither COM nor IDL).
- byte_strobe  output  1  one-cycle pulse at every aligned byte boundary while active.
- active  output  1  lane locked and aligned.

## Operation
- Shift register `sr[7:0]` on every edge: sr_next = {sr[6:0], serial_in}. All comparisons use sr_next, the byte including the bit sampled on the current edge.
- `bitcnt[2:0]` counts bits of the current byte. A byte boundary is an edge with bitcnt==7 before the edge; bitcnt then wraps to 0.
- `comcnt[3:0]` counts consecutive aligned COMs.
- FSM states:
  - HUNT (reset state): on any edge where sr_next==COM: bitcnt<=0, comcnt<=1, go to ALIGN. Otherwise stay; bitcnt is not used.
  - ALIGN: bitcnt increments each edge. At a boundary:
    - sr_next==COM and comcnt+1==LOCK_COUNT -> ACTIVE, active<=1.
    - sr_next==COM otherwise -> comcnt<=comcnt+1.
    - sr_next!=COM -> HUNT, comcnt<=0. The failing byte is not re-tested as a COM.
  - ACTIVE: bitcnt increments. At every boundary: data_out<=sr_next and byte_strobe<=1. valid_out<=1 only if sr_next is neither COM nor IDL. ACTIVE is left only by reset.
- The first COM match in HUNT defines alignment, including one found at an arbitrary bit offset.
- data_out is not updated in HUNT or ALIGN.
- comcnt saturates at its maximum and never wraps.

## Timing
- Reset values: data_out=8'h00, valid_out=0, byte_strobe=0, active=0; sr=0, bitcnt=0, comcnt=0, state HUNT.
- An asynchronous reset assertion mid-byte or in ACTIVE clears everything immediately; after release, hunting restarts from the next edge.
- All outputs are registered.
- Alignment latency: the first COM is detected on the edge that samples its 8th bit. Each following aligned byte completes exactly 8 edges after the previous one.
- Lock: active rises on the edge that samples the last bit of the LOCK_COUNT-th consecutive COM, i.e. 8·(LOCK_COUNT−1) edges after first detection.
- Data latency: for a payload byte whose 8th bit is sampled at edge N, data_out/valid_out/byte_strobe are visible after edge N. valid_out and byte_strobe drop after edge N+1.
- While active, strobes are spaced exactly 8 cycles apart with no gaps.

## Test plan
- Reset: hold reset=0 while toggling serial_in -> all outputs 0. Release with no COM -> active stays 0 indefinitely.
- Clean lock: send 4×8'hBC then 8'hA5 (MSB first) -> active rises on the 32nd bit's edge; data_out=8'hA5 with valid_out=1 for one cycle after bit 40.
- Arbitrary offset: send 3 junk bits (1,0,1), then 4×BC, then 8'h3C -> lock is achieved and data_out=8'h3C, valid_out pulses.
- Broken run: send BC, BC, BC, 8'h00, then 4×BC, then 8'h11 -> active stays 0 until the second run completes; 8'h11 is then reported.
- Filler suppression in ACTIVE: send BC, 7C, 5A -> byte_strobe pulses three times 8 cycles apart; valid_out pulses only for 8'h5A; data_out ends at 8'h5A.
- Reset mid-ACTIVE: assert reset=0 in the middle of a byte -> active, data_out, and strobes clear immediately; relock requires 4 fresh COMs.
